axis_tpg_ctrl: RTL and testbench
================================

AXIS_TPG_CTRL -- requirements
Module: axis_tpg_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width passed through unchanged.
REQ-002 SHALL have parameter FRAME_CNT_W, default 16, width of frame counters.
REQ-003 SHALL have port m_axis_aclk  in  1  clock; reset rst_n, synchronous, active-low; clock m_axis_aclk.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports start, stop  in  1 each  single-cycle command pulses.
REQ-006 SHALL have ports cfg_height  in  16  lines per frame; cfg_frames  in  FRAME_CNT_W  frames to run, 0 = continuous; cfg_gap  in  16  idle cycles between frames.
REQ-007 SHALL have ports cfg_mode_first, cfg_mode_last  in  4 each  mode range; cfg_mode_hold  in  8  frames per mode.
REQ-008 SHALL have port tpg_mode  out  4  mode driven to the pattern generator.
REQ-009 SHALL have ports s_axis_tdata  in  DATA_WIDTH; s_axis_tlast, s_axis_tuser, s_axis_tvalid  in  1; s_axis_tready  out  1 (from the generator).
REQ-010 SHALL have ports m_axis_tdata  out  DATA_WIDTH; m_axis_tlast, m_axis_tuser, m_axis_tvalid  out  1; m_axis_tready  in  1 (downstream).
REQ-011 SHALL have ports busy  out  1; done  out  1 (one-cycle pulse); frame_cnt  out  FRAME_CNT_W; sync_err  out  1 (sticky).

Function
REQ-012 SHALL implement FSM states IDLE, SYNC, RUN, GAP, DONE.
REQ-013 IDLE: start latches all cfg_* and sets tpg_mode=cfg_mode_first, hold_cnt=0, frame_cnt=0, line_cnt=0 -> SYNC; start outside IDLE is ignored.
REQ-014 SYNC: s_axis_tready=1, m_axis_tvalid=0; beats are discarded until s_axis_tvalid=1 with s_axis_tuser=1; that beat is not consumed and the FSM moves to RUN.
REQ-015 RUN: zero-latency pass-through -- m_axis_tdata/tlast/tuser = s_axis_*, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
REQ-016 RUN: line_cnt increments on each handshake with tlast; frame end = tlast handshake with line_cnt==cfg_height-1 (cfg_height 0 treated as 1); line_cnt returns to 0 at frame end.
REQ-017 Frame end SHALL increment frame_cnt (wrap at 2^FRAME_CNT_W); if stop_pending or (cfg_frames!=0 and frame_cnt+1==cfg_frames) -> DONE, else -> GAP.
REQ-018 GAP: s_axis_tready=0, m_axis_tvalid=0 for max(cfg_gap,1) cycles, then -> RUN; the minimum of one cycle lets the generator re-register its first pixel with the new mode.
REQ-019 Mode sequencing at frame end: if hold_cnt==max(cfg_mode_hold,1)-1 then hold_cnt=0 and tpg_mode advances by 1, wrapping from cfg_mode_last to cfg_mode_first; else hold_cnt+1.
REQ-020 If cfg_mode_first>cfg_mode_last, tpg_mode SHALL stay at cfg_mode_first.
REQ-021 tpg_mode SHALL be registered and change only on the frame-end edge or on start.
REQ-022 stop in SYNC SHALL go directly to DONE; in RUN/GAP it sets stop_pending, honoured at the next frame end; a stop in the same cycle as a frame end counts for that frame.
REQ-023 DONE: lasts one cycle with done=1, s_axis_tready=0 -> IDLE; frame_cnt holds its final value until the next start.
REQ-024 In RUN, s_axis_tuser=1 on a handshake with line_cnt!=0 or mid-line SHALL set sync_err; this is flag only, with no state change.
REQ-025 busy SHALL be 1 in SYNC, RUN and GAP.
REQ-026 In IDLE, s_axis_tready=0 and m_axis_tvalid=0.

Reset
REQ-027 Reset SHALL force IDLE, tpg_mode=0, frame_cnt=0, line_cnt=0, hold_cnt=0, gap counter=0, stop_pending=0, sync_err=0, done=0, busy=0, s_axis_tready=0, m_axis_tvalid=0.
REQ-028 Reset mid-frame SHALL take effect on the next edge; the partial frame is abandoned and a following start resynchronises via SYNC.

Structure
REQ-029 Package axis_tpg_ctrl_pkg SHALL hold the FSM state enum, the TPG mode encodings (0 chess, 1 gray_x, 2 gray_y, 3 gray_x_run, 4 gray_y_run, 5 white), and the minimum gap constant 1.
REQ-030 No sub-module SHALL be used; the parent instantiates the generator next to this block.

Verification
REQ-031 Width 8, cfg_height=4, cfg_frames=2, gap=0, mode 1..1, tready=1 -> 64 output beats, one GAP cycle between frames, tuser on beats 0 and 32, done at end, frame_cnt=2.
REQ-032 cfg_mode_first=0, last=2, hold=2, cfg_frames=8 -> per-frame tpg_mode 0,0,1,1,2,2,0,0.
REQ-033 Start while the generator is at mid-frame line 2 -> no m_axis beats until the generator's tuser; the first output beat has tuser=1.
REQ-034 Random m_axis_tready at 50% -> output beat sequence is identical to the tready=1 run; no beat is lost or duplicated.
REQ-035 cfg_frames=0 with stop at line 1 of frame 3 -> frame 3 completes, done follows, frame_cnt=4 (frames 0..3 complete).
REQ-036 Injected tuser at line 2 in RUN -> sync_err=1 and remains 1 until reset; frame counting continues.

Source files
------------

// File: rtl/axis_tpg_ctrl_pkg.sv
// Shared types and constants for the test-pattern-generator frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_tpg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_t;

    // Pattern encodings understood by the generator
    localparam logic [3:0] MODE_CHESS      = 4'd0;
    localparam logic [3:0] MODE_GRAY_X     = 4'd1;
    localparam logic [3:0] MODE_GRAY_Y     = 4'd2;
    localparam logic [3:0] MODE_GRAY_X_RUN = 4'd3;
    localparam logic [3:0] MODE_GRAY_Y_RUN = 4'd4;
    localparam logic [3:0] MODE_WHITE      = 4'd5;

    // Shortest inter-frame gap; gives the generator one cycle to reload its
    // first pixel with the new mode.
    localparam logic [15:0] MIN_GAP = 16'd1;

endpackage

// File: rtl/axis_tpg_ctrl.sv
// Frame sequencer sitting between a pattern generator and its AXI-Stream sink.
// Latency: zero-cycle combinational pass-through of pixels while running.
// Backpressure: downstream tready is forwarded to the generator in RUN; upstream is stalled in IDLE/GAP/DONE.
module axis_tpg_ctrl
    import axis_tpg_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   m_axis_aclk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [15:0]            cfg_height,
    input  logic [FRAME_CNT_W-1:0] cfg_frames,
    input  logic [15:0]            cfg_gap,
    input  logic [3:0]             cfg_mode_first,
    input  logic [3:0]             cfg_mode_last,
    input  logic [7:0]             cfg_mode_hold,
    output logic [3:0]             tpg_mode,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   sync_err
);

    state_t                 state;
    logic [15:0]            height_q;
    logic [FRAME_CNT_W-1:0] frames_q;
    logic [15:0]            gap_q;
    logic [3:0]             mode_first_q;
    logic [3:0]             mode_last_q;
    logic [7:0]             hold_q;
    logic [7:0]             hold_cnt;
    logic [15:0]            line_cnt;
    logic [15:0]            gap_cnt;
    logic                   mid_line;
    logic                   stop_pending;

    logic                   s_hs;
    logic [15:0]            line_last;
    logic [7:0]             hold_last;
    logic [15:0]            gap_load;
    logic [FRAME_CNT_W-1:0] frame_cnt_nxt;
    logic                   frame_end;
    logic                   finish;
    logic [3:0]             mode_nxt;

    assign s_hs          = s_axis_tvalid && s_axis_tready;
    // Zero height/hold are treated as one line / one frame
    assign line_last     = (height_q == 16'd0) ? 16'd0 : height_q - 16'd1;
    assign hold_last     = (hold_q == 8'd0) ? 8'd0 : hold_q - 8'd1;
    assign gap_load      = (gap_q < MIN_GAP) ? 16'd0 : gap_q - MIN_GAP;
    assign frame_cnt_nxt = frame_cnt + 1'b1;
    assign frame_end     = (state == ST_RUN) && s_hs && s_axis_tlast && (line_cnt == line_last);
    // A stop arriving on the frame-end cycle still ends the run on this frame
    assign finish        = stop_pending || stop ||
                           ((frames_q != '0) && (frame_cnt_nxt == frames_q));

    // Next pattern in the configured range; an inverted range pins the first mode
    always_comb begin
        mode_nxt = tpg_mode + 4'd1;
        if (mode_first_q > mode_last_q || tpg_mode >= mode_last_q) begin
            mode_nxt = mode_first_q;
        end
    end

    // Upstream ready per state; in SYNC the start-of-frame beat is held back so RUN forwards it
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_SYNC: s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
            ST_RUN:  s_axis_tready = m_axis_tready;
            default: s_axis_tready = 1'b0;
        endcase
    end

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tvalid = (state == ST_RUN) && s_axis_tvalid;
    assign busy          = (state == ST_SYNC) || (state == ST_RUN) || (state == ST_GAP);
    assign done          = (state == ST_DONE);

    // Frame sequencing FSM with line/frame/mode/gap bookkeeping
    always_ff @(posedge m_axis_aclk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            height_q     <= '0;
            frames_q     <= '0;
            gap_q        <= '0;
            mode_first_q <= '0;
            mode_last_q  <= '0;
            hold_q       <= '0;
            tpg_mode     <= '0;
            hold_cnt     <= '0;
            frame_cnt    <= '0;
            line_cnt     <= '0;
            gap_cnt      <= '0;
            mid_line     <= 1'b0;
            stop_pending <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        height_q     <= cfg_height;
                        frames_q     <= cfg_frames;
                        gap_q        <= cfg_gap;
                        mode_first_q <= cfg_mode_first;
                        mode_last_q  <= cfg_mode_last;
                        hold_q       <= cfg_mode_hold;
                        tpg_mode     <= cfg_mode_first;
                        hold_cnt     <= '0;
                        frame_cnt    <= '0;
                        line_cnt     <= '0;
                        gap_cnt      <= '0;
                        mid_line     <= 1'b0;
                        stop_pending <= 1'b0;
                        state        <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (stop) begin
                        state <= ST_DONE;
                    end else if (s_axis_tvalid && s_axis_tuser) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (s_hs) begin
                        if (s_axis_tuser && (line_cnt != 16'd0 || mid_line)) begin
                            sync_err <= 1'b1;
                        end
                        mid_line <= !s_axis_tlast;
                        if (frame_end) begin
                            line_cnt  <= '0;
                            frame_cnt <= frame_cnt_nxt;
                            if (hold_cnt == hold_last) begin
                                hold_cnt <= '0;
                                tpg_mode <= mode_nxt;
                            end else begin
                                hold_cnt <= hold_cnt + 8'd1;
                            end
                            if (finish) begin
                                state <= ST_DONE;
                            end else begin
                                gap_cnt <= gap_load;
                                state   <= ST_GAP;
                            end
                        end else if (s_axis_tlast) begin
                            line_cnt <= line_cnt + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (gap_cnt == 16'd0) begin
                        state <= ST_RUN;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                ST_DONE: begin
                    stop_pending <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_tpg_ctrl.sv
// Randomised scoreboard bench for axis_tpg_ctrl with a behavioural frame source.
// Latency: n/a.
// Backpressure: source honours tready; sink tready optionally randomised.
module tb_axis_tpg_ctrl;
    localparam int DW = 8;
    localparam int FW = 16;
    localparam int LW = 8;   // pixels per line

    logic          clk = 1'b0;
    logic          rst_n, start, stop;
    logic [15:0]   cfg_height, cfg_gap;
    logic [FW-1:0] cfg_frames;
    logic [3:0]    cfg_mode_first, cfg_mode_last, tpg_mode;
    logic [7:0]    cfg_mode_hold;
    logic [DW-1:0] s_axis_tdata, m_axis_tdata;
    logic          s_axis_tlast, s_axis_tuser, s_axis_tvalid, s_axis_tready;
    logic          m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready;
    logic          busy, done, sync_err;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    axis_tpg_ctrl #(.DATA_WIDTH(DW), .FRAME_CNT_W(FW)) dut (
        .m_axis_aclk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_height(cfg_height), .cfg_frames(cfg_frames), .cfg_gap(cfg_gap),
        .cfg_mode_first(cfg_mode_first), .cfg_mode_last(cfg_mode_last),
        .cfg_mode_hold(cfg_mode_hold), .tpg_mode(tpg_mode),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .frame_cnt(frame_cnt), .sync_err(sync_err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
        logic [3:0]    m;
    } beat_t;

    beat_t src_q[$];
    beat_t exp_q[$];
    int    src_idx;
    bit    src_on, src_rand, rdy_rand;
    int    n_vec, n_err;
    int    out_cnt, done_cnt, gap_cyc;
    bit    first_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Mode expected during frame k, straight from the sequencing rules
    function automatic logic [3:0] exp_mode(input int k, input int first, input int last, input int hold);
        int heff;
        heff = (hold == 0) ? 1 : hold;
        if (first > last) return 4'(first);
        return 4'(first + (k / heff) % (last - first + 1));
    endfunction

    // Frame source: walks src_q, holds a presented beat until it is accepted
    initial begin
        bit hs;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk); #1;
            if (hs) src_idx++;
            if (!src_on || src_idx >= src_q.size()) begin
                s_axis_tvalid = 1'b0;
            end else if (!(s_axis_tvalid && !hs)) begin
                s_axis_tvalid = !src_rand || ($urandom_range(1, 0) == 1);
            end
            if (src_idx < src_q.size()) begin
                s_axis_tdata = src_q[src_idx].d;
                s_axis_tlast = src_q[src_idx].l;
                s_axis_tuser = src_q[src_idx].u;
            end
            m_axis_tready = !rdy_rand || ($urandom_range(1, 0) == 1);
        end
    end

    // Output monitor: pops the scoreboard on every downstream handshake
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(out_cnt), 64'(-1));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser, tpg_mode},
                                {e.d, e.l, e.u, e.m});
                end
                out_cnt++;
                first_seen = 1'b1;
            end
            if (done) done_cnt++;
            if (first_seen && busy && !m_axis_tvalid) gap_cyc++;
        end
    end

    task automatic run_test(input int h, input int frames, input int gap, input int mf, input int ml,
                            input int hold, input int nexp, input int pfx, input bit rv, input bit rr,
                            input int stop_at, input bit inject, input int restart_at,
                            input int exp_gap, input bit exp_serr);
        int  heff;
        bit  stopped, restarted;
        beat_t b;
        heff = (h == 0) ? 1 : h;
        @(negedge clk); #2;
        rst_n = 1'b0; src_on = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("reset", {s_axis_tready, m_axis_tvalid, busy, done, frame_cnt, tpg_mode, sync_err}, 64'd0);
        src_q.delete(); exp_q.delete();
        if (pfx > 0) begin
            for (int l = pfx; l < heff; l++)
                for (int x = 0; x < LW; x++) begin
                    b.d = DW'($urandom); b.l = (x == LW - 1); b.u = 1'b0; b.m = 4'd0;
                    src_q.push_back(b);
                end
        end
        for (int f = 0; f < nexp + 2; f++)
            for (int l = 0; l < heff; l++)
                for (int x = 0; x < LW; x++) begin
                    b.d = DW'($urandom);
                    b.l = (x == LW - 1);
                    b.u = (l == 0 && x == 0) || (inject && f == 0 && l == 2 && x == 0);
                    b.m = exp_mode(f, mf, ml, hold);
                    src_q.push_back(b);
                    if (f < nexp) exp_q.push_back(b);
                end
        src_idx = 0; out_cnt = 0; done_cnt = 0; gap_cyc = 0; first_seen = 1'b0;
        cfg_height = 16'(h); cfg_frames = FW'(frames); cfg_gap = 16'(gap);
        cfg_mode_first = 4'(mf); cfg_mode_last = 4'(ml); cfg_mode_hold = 8'(hold);
        src_rand = rv; rdy_rand = rr; src_on = 1'b1; rst_n = 1'b1;
        stopped = 1'b0; restarted = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0;
            if (stop_at >= 0 && !stopped && out_cnt >= stop_at) begin stop = 1'b1; stopped = 1'b1; end
            if (restart_at >= 0 && !restarted && out_cnt >= restart_at) begin start = 1'b1; restarted = 1'b1; end
            if (done_cnt > 0) break;
        end
        start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("beat_count", 64'(out_cnt), 64'(nexp * heff * LW));
        chk("frame_cnt", 64'(frame_cnt), 64'(nexp));
        chk("sync_err", 64'(sync_err), 64'(exp_serr));
        chk("busy_after", 64'(busy), 64'd0);
        if (exp_gap >= 0) chk("gap_cycles", 64'(gap_cyc), 64'(exp_gap));
    endtask

    initial begin
        int h, f, mf, ml;
        n_vec = 0; n_err = 0; src_idx = 0; src_on = 1'b0; src_rand = 1'b0; rdy_rand = 1'b0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_height = '0; cfg_frames = '0; cfg_gap = '0;
        cfg_mode_first = '0; cfg_mode_last = '0; cfg_mode_hold = '0;
        //       h  frm gap mf ml hold nexp pfx rv rr stop  inj rst  gap  serr
        run_test(4, 2,  0,  1, 1, 1,   2,   0,  0, 0, -1,   0,  -1,  1,   0);
        run_test(2, 8,  2,  0, 2, 2,   8,   0,  0, 0, -1,   0,  5,   14,  0);
        run_test(4, 3,  1,  0, 5, 1,   3,   2,  1, 1, -1,   0,  -1,  -1,  0);
        run_test(3, 4,  5,  2, 4, 0,   4,   1,  1, 1, -1,   0,  -1,  -1,  0);
        run_test(4, 0,  1,  0, 1, 1,   4,   0,  0, 1, 3*4*LW+LW, 0, -1, -1, 0);
        run_test(4, 2,  0,  1, 3, 3,   2,   0,  0, 0, -1,   1,  -1,  1,   1);
        run_test(0, 3,  0,  3, 1, 1,   3,   0,  0, 0, -1,   0,  -1,  2,   0);
        run_test(4, 2,  0,  0, 2, 1,   0,   1,  0, 0, 0,    0,  -1,  -1,  0);
        for (int i = 0; i < 3; i++) begin
            h  = $urandom_range(4, 1);
            f  = $urandom_range(4, 1);
            mf = $urandom_range(5, 0);
            ml = $urandom_range(5, 0);
            run_test(h, f, $urandom_range(3, 0), mf, ml, $urandom_range(3, 0), f,
                     $urandom_range(h - 1, 0), 1, 1, -1, 0, -1, -1, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
